// File: rtl/weight_fetch_buffer.sv
// Weight-ROM read sequencer with a 2-entry FIFO feeding the conv engine.
// Optional ROM watchdog enabled by defining WFB_TIMEOUT_EN.
module weight_fetch_buffer #(
  parameter int unsigned NUM_FILTERS    = 64,
  parameter int unsigned INPUT_CHANNELS = 3,
  parameter int unsigned KERNEL_SIZE    = 3,
  parameter int unsigned WEIGHT_WIDTH   = 8,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  localparam int unsigned KW = KERNEL_SIZE * KERNEL_SIZE * WEIGHT_WIDTH,
  localparam int unsigned FW = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1,
  localparam int unsigned CW = (INPUT_CHANNELS > 1) ? $clog2(INPUT_CHANNELS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          rom_ready,
  output logic [FW-1:0] rom_filter_idx,
  output logic [CW-1:0] rom_channel_idx,
  output logic          rom_read_enable,
  input  logic [KW-1:0] rom_weight,
  input  logic          rom_weight_valid,
  output logic [KW-1:0] wt_data,
  output logic [FW-1:0] wt_filter,
  output logic [CW-1:0] wt_channel,
  output logic          wt_last_ch,
  output logic          wt_valid,
  input  logic          wt_ready,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DRAIN} state_t;

  localparam logic [FW-1:0] F_LAST = FW'(NUM_FILTERS - 1);
  localparam logic [CW-1:0] C_LAST = CW'(INPUT_CHANNELS - 1);

  state_t        r_state;
  state_t        w_next;
  logic [FW-1:0] r_fil;
  logic [CW-1:0] r_ch;
  logic [KW-1:0] r_dat [2];
  logic [FW-1:0] r_ent_f [2];
  logic [CW-1:0] r_ent_c [2];
  logic [1:0]    r_count;

  logic w_push;
  logic w_pop;
  logic w_issue;
  logic w_idx_last;
  logic w_head_last;
  logic w_timeout;

  assign w_push      = (r_state == S_WAIT) && rom_weight_valid;
  assign w_pop       = (r_count != 2'd0) && wt_ready;
  assign w_issue     = (r_state == S_ISSUE) && rom_ready && (r_count < 2'd2);
  assign w_idx_last  = (r_fil == F_LAST) && (r_ch == C_LAST);
  assign w_head_last = (r_ent_f[0] == F_LAST) && (r_ent_c[0] == C_LAST);

`ifdef WFB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_tcnt;
  logic          r_err;

  // Counter restarts on every entry to WAIT; expiry fires on the last allowed WAIT cycle.
  assign w_timeout = (r_state == S_WAIT) && !rom_weight_valid &&
                     (r_tcnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tcnt <= '0;
      r_err  <= 1'b0;
    end else begin
      if (r_state != S_WAIT) r_tcnt <= '0;
      else                   r_tcnt <= r_tcnt + 1'b1;
      if ((r_state == S_IDLE) && start) r_err <= 1'b0;
      else if (w_timeout)               r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign w_timeout = 1'b0;
  assign err       = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next = S_ISSUE;
      S_ISSUE: if (w_issue) w_next = S_WAIT;
      S_WAIT: begin
        if (w_timeout)   w_next = S_IDLE;
        else if (w_push) w_next = w_idx_last ? S_DRAIN : S_ISSUE;
      end
      S_DRAIN: if ((r_count == 2'd0) || (w_pop && w_head_last)) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    rom_read_enable = w_issue;
    busy            = (r_state != S_IDLE);
    done            = (r_state == S_DRAIN) && w_pop && w_head_last;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fil <= '0;
      r_ch  <= '0;
    end else if ((r_state == S_IDLE) && start) begin
      r_fil <= '0;
      r_ch  <= '0;
    end else if (w_push && !w_idx_last) begin
      if (r_ch == C_LAST) begin
        r_ch  <= '0;
        r_fil <= r_fil + 1'b1;
      end else begin
        r_ch  <= r_ch + 1'b1;
      end
    end
  end

  // Entry 0 is always the head; a pop shifts entry 1 down.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count    <= 2'd0;
      r_dat[0]   <= '0;
      r_dat[1]   <= '0;
      r_ent_f[0] <= '0;
      r_ent_f[1] <= '0;
      r_ent_c[0] <= '0;
      r_ent_c[1] <= '0;
    end else if (w_timeout) begin
      r_count <= 2'd0;
    end else begin
      unique case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) begin
            r_dat[0]   <= rom_weight;
            r_ent_f[0] <= r_fil;
            r_ent_c[0] <= r_ch;
          end else begin
            r_dat[1]   <= rom_weight;
            r_ent_f[1] <= r_fil;
            r_ent_c[1] <= r_ch;
          end
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_dat[0]   <= r_dat[1];
          r_ent_f[0] <= r_ent_f[1];
          r_ent_c[0] <= r_ent_c[1];
          r_count    <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_dat[0]   <= rom_weight;
            r_ent_f[0] <= r_fil;
            r_ent_c[0] <= r_ch;
          end else begin
            r_dat[0]   <= r_dat[1];
            r_ent_f[0] <= r_ent_f[1];
            r_ent_c[0] <= r_ent_c[1];
            r_dat[1]   <= rom_weight;
            r_ent_f[1] <= r_fil;
            r_ent_c[1] <= r_ch;
          end
        end
        default: ;
      endcase
    end
  end

  assign rom_filter_idx  = r_fil;
  assign rom_channel_idx = r_ch;
  assign wt_valid        = (r_count != 2'd0);
  assign wt_data         = r_dat[0];
  assign wt_filter       = r_ent_f[0];
  assign wt_channel      = r_ent_c[0];
  assign wt_last_ch      = wt_valid && (r_ent_c[0] == C_LAST);

endmodule

// File: tb/tb_weight_fetch_buffer.sv
// Directed bench for weight_fetch_buffer (NF=4, IC=3, K=3, W=8) with an 11-cycle ROM model.
module tb_weight_fetch_buffer;

  localparam int unsigned NF = 4;
  localparam int unsigned IC = 3;
  localparam int unsigned KW = 72;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          rom_ready = 1'b0;
  logic [1:0]    rom_filter_idx;
  logic [1:0]    rom_channel_idx;
  logic          rom_read_enable;
  logic [KW-1:0] rom_weight = '0;
  logic          rom_weight_valid = 1'b0;
  logic [KW-1:0] wt_data;
  logic [1:0]    wt_filter;
  logic [1:0]    wt_channel;
  logic          wt_last_ch;
  logic          wt_valid;
  logic          wt_ready = 1'b0;
  logic          busy;
  logic          done;
  logic          err;

  always #5 clk = ~clk;

  weight_fetch_buffer #(
    .NUM_FILTERS   (4),
    .INPUT_CHANNELS(3),
    .KERNEL_SIZE   (3),
    .WEIGHT_WIDTH  (8),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .rom_ready       (rom_ready),
    .rom_filter_idx  (rom_filter_idx),
    .rom_channel_idx (rom_channel_idx),
    .rom_read_enable (rom_read_enable),
    .rom_weight      (rom_weight),
    .rom_weight_valid(rom_weight_valid),
    .wt_data         (wt_data),
    .wt_filter       (wt_filter),
    .wt_channel      (wt_channel),
    .wt_last_ch      (wt_last_ch),
    .wt_valid        (wt_valid),
    .wt_ready        (wt_ready),
    .busy            (busy),
    .done            (done),
    .err             (err)
  );

  function automatic logic [KW-1:0] kern(int f, int c);
    logic [KW-1:0] k;
    k = '0;
    for (int i = 0; i < 9; i++) k[i*8 +: 8] = 8'(f*27 + c*9 + i + 1);
    return k;
  endfunction

  // ROM: answers a read 11 cycles later unless muted; reset cancels a pending read.
  int   rom_cnt = 0;
  logic [1:0] rom_f = '0;
  logic [1:0] rom_c = '0;
  logic rom_mute = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      rom_cnt = 0;
      rom_weight_valid = 1'b0;
    end else begin
      rom_weight_valid = 1'b0;
      if (rom_read_enable) begin
        rom_cnt = 11;
        rom_f = rom_filter_idx;
        rom_c = rom_channel_idx;
      end else if (rom_cnt > 0) begin
        rom_cnt = rom_cnt - 1;
        if (rom_cnt == 0 && !rom_mute) begin
          rom_weight_valid = 1'b1;
          rom_weight = kern(int'(rom_f), int'(rom_c));
        end
      end
    end
  end

  int            n_reads = 0, n_bad_reads = 0, n_beats = 0, n_done = 0, done_at = -1;
  logic [1:0]    rd_f [512];
  logic [1:0]    rd_c [512];
  logic [1:0]    bt_f [512];
  logic [1:0]    bt_c [512];
  logic [KW-1:0] bt_d [512];
  logic          bt_l [512];

  always @(negedge clk) begin
    if (rst_n) begin
      if (rom_read_enable && n_reads < 512) begin
        rd_f[n_reads] = rom_filter_idx;
        rd_c[n_reads] = rom_channel_idx;
        n_reads++;
        if (!rom_ready) n_bad_reads++;
      end
      if (wt_valid && wt_ready && n_beats < 512) begin
        bt_f[n_beats] = wt_filter;
        bt_c[n_beats] = wt_channel;
        bt_d[n_beats] = wt_data;
        bt_l[n_beats] = wt_last_ch;
        n_beats++;
      end
      if (done) begin
        n_done++;
        done_at = n_beats;
      end
    end
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int maxc);
    int k;
    k = 0;
    while (busy && k < maxc) begin
      step();
      k++;
    end
    chk({tag, " sweep ends"}, busy, 1'b0);
  endtask

  task automatic check_sweep(input string tag, input int b_beats, input int b_reads, input int b_done);
    int f, c;
    chk({tag, " reads"}, n_reads - b_reads, 12);
    chk({tag, " beats"}, n_beats - b_beats, 12);
    chk({tag, " done count"}, n_done - b_done, 1);
    chk({tag, " done on last pop"}, done_at, b_beats + 12);
    for (int j = 0; j < 12; j++) begin
      f = j / 3;
      c = j % 3;
      chk($sformatf("%s rd%0d f", tag, j), rd_f[b_reads + j], f);
      chk($sformatf("%s rd%0d c", tag, j), rd_c[b_reads + j], c);
      chk($sformatf("%s bt%0d f", tag, j), bt_f[b_beats + j], f);
      chk($sformatf("%s bt%0d c", tag, j), bt_c[b_beats + j], c);
      chk($sformatf("%s bt%0d data", tag, j), bt_d[b_beats + j], kern(f, c));
      chk($sformatf("%s bt%0d last", tag, j), bt_l[b_beats + j], (c == IC - 1));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global timeout: observed no finish, expected finish");
    $fatal(1, "bench stuck");
  end

  initial begin
    int b_beats, b_reads, b_done, b_bad, k, r0;
    logic prev_valid;

    rom_ready = 1'b1;
    repeat (3) step();
    chk("rst busy", busy, 1'b0);
    chk("rst wt_valid", wt_valid, 1'b0);
    chk("rst read_en", rom_read_enable, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst err", err, 1'b0);
    chk("rst wt_data", wt_data, '0);
    chk("rst idx", {rom_filter_idx, rom_channel_idx}, 4'h0);
    rst_n = 1'b1;
    step();

    // Test 1: free-flowing sweep
    wt_ready = 1'b1;
    b_beats = n_beats; b_reads = n_reads; b_done = n_done; b_bad = n_bad_reads;
    pulse_start();
    chk("t1 busy after start", busy, 1'b1);
    k = 0;
    while (!done && k < 1000) begin
      step();
      k++;
    end
    chk("t1 done seen", done, 1'b1);
    step();
    chk("t1 busy falls after done", busy, 1'b0);
    check_sweep("t1", b_beats, b_reads, b_done);
    chk("t1 beat(1,2) byte0", bt_d[b_beats + 5][7:0], 8'h2E);
    chk("t1 no read while not ready", n_bad_reads - b_bad, 0);

    // Test 2: consumer stalls; only two reads may be outstanding in the buffer
    wt_ready = 1'b0;
    b_beats = n_beats; b_reads = n_reads; b_done = n_done;
    pulse_start();
    prev_valid = wt_valid;
    k = 0;
    while (!rom_weight_valid && k < 40) begin
      prev_valid = wt_valid;
      step();
      k++;
    end
    chk("t2 first capture seen", rom_weight_valid, 1'b1);
    chk("t2 wt_valid low before capture", prev_valid, 1'b0);
    chk("t2 wt_valid after capture", wt_valid, 1'b1);
    chk("t2 head data", wt_data, kern(0, 0));
    chk("t2 head last_ch", wt_last_ch, 1'b0);
    repeat (48 - k) step();
    chk("t2 reads while stalled", n_reads - b_reads, 2);
    chk("t2 holding valid", wt_valid, 1'b1);
    chk("t2 holding tag", {wt_filter, wt_channel}, 4'h0);
    chk("t2 still busy", busy, 1'b1);
    wt_ready = 1'b1;
    wait_idle("t2", 1000);
    check_sweep("t2", b_beats, b_reads, b_done);

    // Test 3: ROM busy-loading mid sweep
    b_beats = n_beats; b_reads = n_reads; b_done = n_done; b_bad = n_bad_reads;
    pulse_start();
    k = 0;
    while (n_reads - b_reads < 4 && k < 200) begin
      step();
      k++;
    end
    rom_ready = 1'b0;
    r0 = n_reads;
    repeat (40) step();
    chk("t3 no reads while rom not ready", n_reads, r0);
    rom_ready = 1'b1;
    wait_idle("t3", 1000);
    check_sweep("t3", b_beats, b_reads, b_done);
    chk("t3 read gated by rom_ready", n_bad_reads - b_bad, 0);

    // Test 4: start while busy is ignored
    b_beats = n_beats; b_reads = n_reads; b_done = n_done;
    pulse_start();
    k = 0;
    while (n_beats - b_beats < 5 && k < 400) begin
      step();
      k++;
    end
    pulse_start();
    wait_idle("t4", 1000);
    check_sweep("t4", b_beats, b_reads, b_done);
    repeat (5) step();
    chk("t4 no extra reads", n_reads - b_reads, 12);

    // Test 5: async reset while waiting on the ROM
    b_reads = n_reads;
    pulse_start();
    k = 0;
    while (n_reads == b_reads && k < 20) begin
      step();
      k++;
    end
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("t5 async busy", busy, 1'b0);
    chk("t5 async wt_valid", wt_valid, 1'b0);
    chk("t5 async read_en", rom_read_enable, 1'b0);
    chk("t5 async done", done, 1'b0);
    chk("t5 async wt_data", wt_data, '0);
    chk("t5 async idx", {rom_filter_idx, rom_channel_idx, wt_filter, wt_channel}, 8'h00);
    repeat (3) step();
    rst_n = 1'b1;
    step();
    b_beats = n_beats; b_reads = n_reads; b_done = n_done;
    pulse_start();
    wait_idle("t5", 1000);
    check_sweep("t5", b_beats, b_reads, b_done);

`ifdef WFB_TIMEOUT_EN
    // Test 6: ROM never answers
    rom_mute = 1'b1;
    b_reads = n_reads; b_done = n_done;
    pulse_start();
    k = 0;
    while (n_reads == b_reads && k < 20) begin
      step();
      k++;
    end
    k = 0;
    while (!err && k < 200) begin
      step();
      k++;
    end
    chk("t6 timeout latency", k, 64);
    chk("t6 err", err, 1'b1);
    chk("t6 busy", busy, 1'b0);
    chk("t6 wt_valid", wt_valid, 1'b0);
    chk("t6 no done", n_done - b_done, 0);
    rom_mute = 1'b0;
    repeat (15) step();
    b_beats = n_beats; b_reads = n_reads; b_done = n_done;
    pulse_start();
    chk("t6 err cleared by start", err, 1'b0);
    wait_idle("t6", 1000);
    check_sweep("t6", b_beats, b_reads, b_done);
`else
    chk("err tied low", err, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
